acc_seq_ctrl: RTL and testbench

Multi-cycle command sequencer that drives the shared ALU and the 8-bit accumulator register. It accepts one command at a time over a valid/ready handshake and drives the ALU opcode and operand. It fires a single-cycle write or clear strobe into the accumulator, then returns the resulting accumulator value over a response handshake. It sits between the front-end instruction source and the ALU/accumulator datapath and is their only master.

---
 rtl/acc_seq_pkg.sv | 48 ++++
 rtl/acc_seq_ctrl_ovf.sv | 20 ++
 rtl/acc_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_acc_seq_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/acc_seq_pkg.sv
// acc_seq_pkg: shared encodings for the accumulator command sequencer.
// Holds the command opcodes, the ALU function codes, the controller state
// enumeration and the command-to-ALU opcode mapping.
package acc_seq_pkg;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_LOAD = 3'd1,
        CMD_ADD  = 3'd2,
        CMD_SUB  = 3'd3,
        CMD_AND  = 3'd4,
        CMD_OR   = 3'd5,
        CMD_XOR  = 3'd6,
        CMD_CLR  = 3'd7
    } cmd_op_e;

    typedef enum logic [2:0] {
        ALU_PASS_B = 3'd0,
        ALU_ADD    = 3'd1,
        ALU_SUB    = 3'd2,
        ALU_AND    = 3'd3,
        ALU_OR     = 3'd4,
        ALU_XOR    = 3'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Width of the EXEC dwell counter; covers EXEC_CYCLES up to 15.
    localparam int CNT_W = 4;

    // LOAD, NOP and CLR all route operand B straight through the ALU.
    function automatic alu_op_e cmd_to_alu(input cmd_op_e op);
        case (op)
            CMD_ADD: return ALU_ADD;
            CMD_SUB: return ALU_SUB;
            CMD_AND: return ALU_AND;
            CMD_OR:  return ALU_OR;
            CMD_XOR: return ALU_XOR;
            default: return ALU_PASS_B;
        endcase
    endfunction

endpackage

// File: rtl/acc_seq_ctrl_ovf.sv
// acc_seq_ovf: DATA_W-bit unsigned carry/borrow detector.
// Flags a carry out of a + b, or a borrow of a - b when sub_i is set.
module acc_seq_ovf #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              sub_i,
    output logic              ovf_o
);

    logic [DATA_W:0] ext_add;
    logic [DATA_W:0] ext_sub;

    // One extra bit catches the carry, or the wrap-around borrow.
    assign ext_add = {1'b0, a_i} + {1'b0, b_i};
    assign ext_sub = {1'b0, a_i} - {1'b0, b_i};
    assign ovf_o   = sub_i ? ext_sub[DATA_W] : ext_add[DATA_W];

endmodule

// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl: multi-cycle command sequencer mastering the ALU and the
// accumulator. Accepts a command, holds ALU inputs for EXEC_CYCLES, fires
// one write or clear strobe, then returns the accumulator value.
// Optional feature macro: ACC_SEQ_OVF_EN (unsigned ADD/SUB overflow
// detection with write suppression and a sticky ovf flag).
module acc_seq_ctrl
    import acc_seq_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int EXEC_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] acc_value,
    output logic              acc_update,
    output logic              acc_clear,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              ovf,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

    state_e            state_q;
    cmd_op_e           op_q;
    cmd_op_e           cmd_in;
    alu_op_e           alu_op_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              acc_update_q;
    logic              acc_clear_q;
    logic              rsp_valid_q;
    logic              rsp_first_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              exec_done;
    logic              ovf_hit;

    assign cmd_in    = cmd_op_e'(cmd_op);
    assign exec_done = (state_q == ST_EXEC) && (cnt_q == '0);

`ifdef ACC_SEQ_OVF_EN
    logic carry;
    logic ovf_q;

    acc_seq_ovf #(
        .DATA_W (DATA_W)
    ) u_ovf (
        .a_i   (acc_value),
        .b_i   (alu_b_q),
        .sub_i (op_q == CMD_SUB),
        .ovf_o (carry)
    );

    assign ovf_hit = carry && ((op_q == CMD_ADD) || (op_q == CMD_SUB));

    // Sticky overflow: set by a suppressed ADD/SUB, cleared only by CLR.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else if (exec_done) begin
            if (op_q == CMD_CLR)
                ovf_q <= 1'b0;
            else if (ovf_hit)
                ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf_hit = 1'b0;
    assign ovf     = 1'b0;
`endif

    // Command FSM with registered ALU inputs, strobes and response valid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            op_q         <= CMD_NOP;
            alu_op_q     <= ALU_PASS_B;
            alu_b_q      <= '0;
            cnt_q        <= '0;
            acc_update_q <= 1'b0;
            acc_clear_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_first_q  <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q     <= cmd_in;
                        alu_op_q <= cmd_to_alu(cmd_in);
                        alu_b_q  <= (cmd_in == CMD_CLR) ? '0 : cmd_data;
                        cnt_q    <= CNT_LOAD;
                        if (cmd_in == CMD_NOP) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_first_q <= 1'b1;
                        end else begin
                            state_q <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_WRITE;
                        if (op_q == CMD_CLR)
                            acc_clear_q <= 1'b1;
                        else if (!ovf_hit)
                            acc_update_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_WRITE: begin
                    acc_update_q <= 1'b0;
                    acc_clear_q  <= 1'b0;
                    rsp_valid_q  <= 1'b1;
                    rsp_first_q  <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    // The accumulator settles on RESP entry; freeze it once.
                    rsp_first_q <= 1'b0;
                    if (rsp_first_q)
                        rsp_data_q <= acc_value;
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // In the RESP entry cycle the freshly written accumulator is passed
    // through; it cannot move afterwards because this block is its only master.
    assign rsp_data   = rsp_first_q ? acc_value : rsp_data_q;
    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign alu_op     = alu_op_q;
    assign alu_b      = alu_b_q;
    assign acc_update = acc_update_q;
    assign acc_clear  = acc_clear_q;
    assign rsp_valid  = rsp_valid_q;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Self-checking bench for acc_seq_ctrl with an accumulator/ALU environment
// and a command-level reference model. Honours ACC_SEQ_OVF_EN if defined.
module tb_acc_seq_ctrl;

    localparam int DW = 8;
    localparam int EC = 2;
`ifdef ACC_SEQ_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic          clock     = 1'b0;
    logic          reset     = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          rsp_ready = 1'b1;
    logic [2:0]    cmd_op    = 3'd0;
    logic [DW-1:0] cmd_data  = '0;
    logic [DW-1:0] acc       = '0;
    logic          cmd_ready, acc_update, acc_clear, rsp_valid, ovf, busy;
    logic [2:0]    alu_op;
    logic [DW-1:0] alu_b, rsp_data;

    int total  = 0;
    int passed = 0;
    int m_acc  = 0;
    bit m_ovf  = 1'b0;

    acc_seq_ctrl #(.DATA_W(DW), .EXEC_CYCLES(EC)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .alu_op     (alu_op),
        .alu_b      (alu_b),
        .acc_value  (acc),
        .acc_update (acc_update),
        .acc_clear  (acc_clear),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .ovf        (ovf),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Environment: the shared ALU and the accumulator register.
    always @(posedge clock) begin
        if (acc_update) begin
            case (alu_op)
                3'd0: acc <= alu_b;
                3'd1: acc <= acc + alu_b;
                3'd2: acc <= acc - alu_b;
                3'd3: acc <= acc & alu_b;
                3'd4: acc <= acc | alu_b;
                3'd5: acc <= acc ^ alu_b;
                default: acc <= acc;
            endcase
        end else if (acc_clear) begin
            acc <= '0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".cmd_ready"}, 32'(cmd_ready), 1);
        chk({tag, ".alu_op"}, 32'(alu_op), 0);
        chk({tag, ".alu_b"}, 32'(alu_b), 0);
        chk({tag, ".strobes"}, {30'd0, acc_update, acc_clear}, 0);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, ".rsp_data"}, 32'(rsp_data), 0);
        chk({tag, ".ovf_busy"}, {30'd0, ovf, busy}, 0);
    endtask

    // ALU function the spec assigns to each command.
    function automatic int exp_alu_op(input int op);
        case (op)
            2: return 1;
            3: return 2;
            4: return 3;
            5: return 4;
            6: return 5;
            default: return 0;
        endcase
    endfunction

    // Issue one command, follow it to its response, then complete the handshake
    // after `stall` cycles of rsp_ready=0 (during which nop/nd is held pending).
    task automatic do_cmd(input logic [2:0] op, input logic [7:0] d, input int stall,
                          input logic [2:0] nop, input logic [7:0] nd, input string tag);
        int  upd_cnt, clr_cnt, both, upd_at, clr_at, rsp_cyc, exp_rsp_cyc;
        bit  exp_upd, exp_clr, stable;
        exp_upd = 0;
        exp_clr = 0;
        case (op)
            3'd1: begin m_acc = d; exp_upd = 1; end
            3'd2: if (OVF_EN && (m_acc + d > 255)) m_ovf = 1;
                  else begin m_acc = (m_acc + d) % 256; exp_upd = 1; end
            3'd3: if (OVF_EN && (d > m_acc)) m_ovf = 1;
                  else begin m_acc = (m_acc - d + 256) % 256; exp_upd = 1; end
            3'd4: begin m_acc = m_acc & d; exp_upd = 1; end
            3'd5: begin m_acc = m_acc | d; exp_upd = 1; end
            3'd6: begin m_acc = m_acc ^ d; exp_upd = 1; end
            3'd7: begin m_acc = 0; m_ovf = 0; exp_clr = 1; end
            default: ;
        endcase
        exp_rsp_cyc = (op == 3'd0) ? 1 : EC + 2;

        cmd_op    = op;
        cmd_data  = d;
        cmd_valid = 1'b1;
        rsp_ready = (stall == 0);
        chk({tag, ".ready"}, 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        chk({tag, ".alu_op"}, 32'(alu_op), 32'(exp_alu_op(int'(op))));
        chk({tag, ".alu_b"}, 32'(alu_b), (op == 3'd7) ? 32'd0 : 32'(d));
        chk({tag, ".busy"}, 32'(busy), 1);

        upd_cnt = 0; clr_cnt = 0; both = 0; upd_at = -1; clr_at = -1; rsp_cyc = -1;
        for (int c = 1; c <= EC + 4; c++) begin
            if (acc_update) begin upd_cnt++; upd_at = c; end
            if (acc_clear) begin clr_cnt++; clr_at = c; end
            if (acc_update && acc_clear) both++;
            if (rsp_valid) begin rsp_cyc = c; break; end
            tick();
        end
        chk({tag, ".rsp_cycle"}, 32'(rsp_cyc), 32'(exp_rsp_cyc));
        chk({tag, ".upd_cnt"}, 32'(upd_cnt), 32'(exp_upd));
        chk({tag, ".upd_at"}, 32'(upd_at), exp_upd ? 32'(EC + 1) : 32'hFFFF_FFFF);
        chk({tag, ".clr_cnt"}, 32'(clr_cnt), 32'(exp_clr));
        chk({tag, ".clr_at"}, 32'(clr_at), exp_clr ? 32'(EC + 1) : 32'hFFFF_FFFF);
        chk({tag, ".both"}, 32'(both), 0);
        chk({tag, ".rsp_data"}, 32'(rsp_data), 32'(m_acc));
        chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));

        stable = 1'b1;
        for (int k = 0; k < stall; k++) begin
            cmd_op    = nop;
            cmd_data  = nd;
            cmd_valid = 1'b1;
            if (rsp_data !== 8'(m_acc) || cmd_ready !== 1'b0 || rsp_valid !== 1'b1)
                stable = 1'b0;
            tick();
        end
        if (stall > 0)
            chk({tag, ".stall_stable"}, 32'(stable), 1);
        rsp_ready = 1'b1;
        tick();
        chk({tag, ".rsp_done"}, {30'd0, rsp_valid, busy}, 0);
        chk({tag, ".idle_ready"}, 32'(cmd_ready), 1);
        chk({tag, ".acc"}, 32'(acc), 32'(m_acc));
    endtask

    initial begin
        logic [2:0] r_op [0:30];
        logic [7:0] r_d  [0:30];
        int         upd_seen;

        // Reset state
        #1;
        chk_reset("reset");
        tick();
        tick();
        reset = 1'b1;
        tick();

        // ADD 5 from a zero accumulator
        do_cmd(3'd2, 8'h05, 0, 3'd0, 8'h00, "add5");
        // LOAD then SUB
        do_cmd(3'd1, 8'h40, 0, 3'd0, 8'h00, "load40");
        do_cmd(3'd3, 8'h10, 0, 3'd0, 8'h00, "sub10");
        // Overflowing ADD, then CLR
        do_cmd(3'd1, 8'hF0, 0, 3'd0, 8'h00, "loadF0");
        do_cmd(3'd2, 8'h20, 0, 3'd0, 8'h00, "add20_ovf");
        do_cmd(3'd7, 8'h5A, 0, 3'd0, 8'h00, "clr_after_ovf");
        // Borrowing SUB
        do_cmd(3'd3, 8'h01, 0, 3'd0, 8'h00, "sub_borrow");
        do_cmd(3'd7, 8'h00, 0, 3'd0, 8'h00, "clr2");
        // Response stall with a pending command held by the source
        do_cmd(3'd1, 8'h55, 10, 3'd2, 8'h03, "stall_load");
        do_cmd(3'd2, 8'h03, 0, 3'd0, 8'h00, "after_stall");

        // Reset during EXEC of ADD 7
        cmd_op = 3'd2; cmd_data = 8'h07; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk_reset("mid_reset");
        m_ovf = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        upd_seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (acc_update || acc_clear || rsp_valid) upd_seen++;
        end
        chk("post_reset.no_strobe", 32'(upd_seen), 0);
        chk("post_reset.acc", 32'(acc), 32'(m_acc));

        // NOP then CLR
        do_cmd(3'd0, 8'h99, 0, 3'd0, 8'h00, "nop");
        do_cmd(3'd7, 8'h11, 0, 3'd0, 8'h00, "clr_final");

        // Randomized command stream with random response back-pressure
        for (int i = 0; i <= 30; i++) begin
            r_op[i] = 3'($urandom_range(0, 7));
            r_d[i]  = 8'($urandom);
        end
        for (int i = 0; i < 30; i++)
            do_cmd(r_op[i], r_d[i], int'($urandom_range(0, 3)), r_op[i+1], r_d[i+1], "rand");
        cmd_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
